// File: rtl/bas_pkg.sv
// Shared constants, types and the 4-bit borrow generate/propagate reduction
// for the borrow-lookahead subtractor.
package bas_pkg;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Borrow out of a 4-bit group with zero borrow-in, and whether
  // a borrow-in would pass straight through the whole group.
  function automatic gp_t group_gp(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p
  );
    gp_t r;
    r.g = g[3]
        | (p[3] & g[2])
        | (p[3] & p[2] & g[1])
        | (p[3] & p[2] & p[1] & g[0]);
    r.p = &p;
    return r;
  endfunction

endpackage

// File: rtl/bas_lookahead4.sv
// Combinational 4-wide borrow lookahead: internal borrows plus
// group generate/propagate.
module bas_lookahead4
  import bas_pkg::*;
(
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:1] c,
  output logic       G,
  output logic       P
);

  gp_t gp;

  always_comb begin
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    gp   = group_gp(g, p);
    G    = gp.g;
    P    = gp.p;
  end

endmodule

// File: rtl/borrow_ahead_subtractor16.sv
// Two-stage borrow-lookahead subtractor with valid/ready on both sides.
// Define BAS_SIGNED_OVF_EN to add a registered two's-complement ovf output.
module borrow_ahead_subtractor16
  import bas_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             Gm,
  output logic             Pm
`ifdef BAS_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / GROUP;

  // handshake
  logic v1;
  logic v2;
  logic s2_free;
  logic load;
  logic adv;

  assign s2_free   = !v2 | out_ready;
  assign in_ready  = !v1 | s2_free;
  assign load      = in_valid & in_ready;
  assign adv       = v1 & s2_free;
  assign out_valid = v2;

  // stage 1 combinational terms
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic [NG-1:0]    gg0;
  logic [NG-1:0]    pg0;

  assign g0 = ~a & b;
  assign p0 = ~(a ^ b);

  for (genvar k = 0; k < NG; k++) begin : g_s1
    assign {gg0[k], pg0[k]} =
      group_gp(g0[GROUP*k +: GROUP], p0[GROUP*k +: GROUP]);
  end

  // stage 1 registers
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] p1;
  logic [NG-1:0]    gg1;
  logic [NG-1:0]    pg1;
  logic             bin1;
`ifdef BAS_SIGNED_OVF_EN
  logic             a_msb1;
  logic             b_msb1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      x1   <= '0;
      g1   <= '0;
      p1   <= '0;
      gg1  <= '0;
      pg1  <= '0;
      bin1 <= 1'b0;
`ifdef BAS_SIGNED_OVF_EN
      a_msb1 <= 1'b0;
      b_msb1 <= 1'b0;
`endif
    end else begin
      v1 <= load | (v1 & !adv);
      if (load) begin
        x1   <= a ^ b;
        g1   <= g0;
        p1   <= p0;
        gg1  <= gg0;
        pg1  <= pg0;
        bin1 <= bin;
`ifdef BAS_SIGNED_OVF_EN
        a_msb1 <= a[WIDTH-1];
        b_msb1 <= b[WIDTH-1];
`endif
      end
    end
  end

  // stage 2: group borrow-ins by lookahead
  logic [3:1]       top_c;
  logic [NG-1:0]    cg;
  logic             gm_c;
  logic             pm_c;

  bas_lookahead4 u_top (
    .g   (gg1),
    .p   (pg1),
    .cin (bin1),
    .c   (top_c),
    .G   (gm_c),
    .P   (pm_c)
  );

  assign cg = {top_c, bin1};

  // per-group internal borrows
  logic [WIDTH-1:0] br;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;

  for (genvar k = 0; k < NG; k++) begin : g_s2
    logic [3:1] ci;
    bas_lookahead4 u_grp (
      .g   (g1[GROUP*k +: GROUP]),
      .p   (p1[GROUP*k +: GROUP]),
      .cin (cg[k]),
      .c   (ci),
      .G   (grp_g[k]),
      .P   (grp_p[k])
    );
    assign br[GROUP*k +: GROUP] = {ci, cg[k]};
  end

  // group G/P are already registered from stage 1
  logic unused_grp;
  assign unused_grp = ^{grp_g, grp_p};

  logic [WIDTH-1:0] diff_c;
  logic             bout_c;

  assign diff_c = x1 ^ br;
  assign bout_c = gm_c | (pm_c & bin1);

`ifdef BAS_SIGNED_OVF_EN
  logic ovf_c;
  assign ovf_c = (a_msb1 ^ b_msb1)
               & (diff_c[WIDTH-1] ^ a_msb1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      Gm   <= 1'b0;
      Pm   <= 1'b0;
`ifdef BAS_SIGNED_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (s2_free) begin
      v2 <= v1;
      if (v1) begin
        diff <= diff_c;
        bout <= bout_c;
        Gm   <= gm_c;
        Pm   <= pm_c;
`ifdef BAS_SIGNED_OVF_EN
        ovf  <= ovf_c;
`endif
      end
    end
  end

endmodule
